// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide RAM sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_ctrl_pkg;

    // Generic enable/disable levels and the all-zero word
    localparam logic        Enable    = 1'b1;
    localparam logic        Disable   = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Memory-mapped UART byte that can refuse writes while its buffer is full
    localparam logic [31:0] IO_ADDR = 32'h0003_0000;

    // Transfer length codes, in bytes
    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Everything the sequencer needs about a transfer besides its address
    typedef struct packed {
        logic        we;
        logic [2:0]  len;
        logic [31:0] wdata;
    } xfer_t;

    // Anything other than a byte or halfword request moves a full word
    function automatic logic [2:0] len_decode(input logic [2:0] len);
        case (len)
            LEN_B:   return LEN_B;
            LEN_H:   return LEN_H;
            default: return LEN_W;
        endcase
    endfunction

    // Little-endian byte lane select
    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[8*idx +: 8];
    endfunction

endpackage

// File: rtl/mem_ctrl_byte_sequencer.sv
// Walks one 1/2/4-byte transfer over the byte RAM: address stepping, write lanes, read packing.
// Latency: reads finish n+1 cycles after start (data merged on the last), writes after n write cycles.
// Backpressure: a write to IO_ADDR while the UART buffer is full holds address/count and retries.
module byte_sequencer #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(mem_ctrl_pkg::IO_ADDR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    start_addr,
    input  mem_ctrl_pkg::xfer_t  start_xfer,
    input  logic                 run,
    input  logic                 io_buffer_full,
    input  logic [7:0]           ram_din,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_wr,
    output logic [7:0]           ram_dout,
    output logic                 last,
    output logic [31:0]          data_next
);
    import mem_ctrl_pkg::*;

    // Read: cnt is the cycle index minus one, so byte cnt-1 is on ram_din.
    // Write: cnt is the lane currently presented on ram_dout.
    logic [2:0]        cnt;
    logic [2:0]        len_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [31:0]       buf_q;
    logic [2:0]        cnt_inc;
    logic [ADDR_W-1:0] addr_inc;

    assign cnt_inc  = cnt + 3'd1;
    assign addr_inc = ram_addr + ADDR_W'(1);

    function automatic logic io_stall(input logic [ADDR_W-1:0] a, input logic full);
        return (a == IO_ADDR) && full;
    endfunction

    // Merge the byte returned this cycle into the word being assembled
    always_comb begin
        data_next = buf_q;
        if (!we_q) begin
            for (int k = 0; k < 4; k++) begin
                if (cnt == 3'(k + 1)) begin
                    data_next[8*k +: 8] = ram_din;
                end
            end
        end
    end

    // Read completes once the final byte is on ram_din; write once the final lane is strobed
    assign last = run && (we_q ? (ram_wr && (cnt_inc == len_q)) : (cnt == len_q));

    // Load a new transfer, then step through its bytes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 3'd0;
            len_q    <= 3'd0;
            we_q     <= Disable;
            wdata_q  <= ZERO_WORD;
            buf_q    <= ZERO_WORD;
            ram_addr <= '0;
            ram_wr   <= Disable;
            ram_dout <= 8'h00;
        end else if (start) begin
            cnt      <= 3'd0;
            len_q    <= start_xfer.len;
            we_q     <= start_xfer.we;
            wdata_q  <= start_xfer.wdata;
            buf_q    <= ZERO_WORD;
            ram_addr <= start_addr;
            ram_dout <= start_xfer.we ? start_xfer.wdata[7:0] : 8'h00;
            ram_wr   <= start_xfer.we && !io_stall(start_addr, io_buffer_full);
        end else if (run) begin
            if (we_q) begin
                if (!ram_wr) begin
                    // Stalled on the UART: same lane, same address, try again
                    ram_wr <= !io_stall(ram_addr, io_buffer_full);
                end else if (cnt_inc == len_q) begin
                    ram_wr <= Disable;
                end else begin
                    cnt      <= cnt_inc;
                    ram_addr <= addr_inc;
                    ram_dout <= get_byte(wdata_q, cnt_inc[1:0]);
                    ram_wr   <= !io_stall(addr_inc, io_buffer_full);
                end
            end else begin
                buf_q <= data_next;
                if (cnt != len_q) begin
                    cnt <= cnt_inc;
                end
                // The address stops on the last byte rather than running past the transfer
                if (cnt_inc < len_q) begin
                    ram_addr <= addr_inc;
                end
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide RAM between instruction fetch (word reads) and MEM loads/stores.
// Latency: reads ready n+2 cycles after the request cycle, writes n+1 (plus any UART stall cycles).
// Backpressure: one transaction at a time, MEM before IF, no preemption; if_jump_i aborts an IF read.
module mem_ctrl #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(mem_ctrl_pkg::IO_ADDR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_jump_i,
    output logic              if_ready_o,
    output logic [31:0]       if_inst_o,
    output logic              is_if_output_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [2:0]        mem_len_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_ready_o,
    output logic [31:0]       mem_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i,
    input  logic              io_buffer_full_i
);
    import mem_ctrl_pkg::*;

    state_t            state;
    logic              start;
    logic              run;
    logic              abort;
    logic              seq_last;
    logic [ADDR_W-1:0] start_addr;
    xfer_t             start_xfer;
    logic [31:0]       data_next;

    // Pick the request to launch from IDLE: MEM wins, IF always fetches a full word
    always_comb begin
        start_addr       = if_addr_i;
        start_xfer.we    = Disable;
        start_xfer.len   = LEN_W;
        start_xfer.wdata = ZERO_WORD;
        if (mem_req_i) begin
            start_addr       = mem_addr_i;
            start_xfer.we    = mem_we_i;
            start_xfer.len   = len_decode(mem_len_i);
            start_xfer.wdata = mem_wdata_i;
        end
    end

    assign start = (state == ST_IDLE) && (mem_req_i || if_req_i);
    assign abort = (state == ST_IF_RD) && if_jump_i;
    assign run   = ((state == ST_IF_RD) || (state == ST_MEM_RD) || (state == ST_MEM_WR)) && !abort;

    byte_sequencer #(
        .ADDR_W  (ADDR_W),
        .IO_ADDR (IO_ADDR)
    ) u_seq (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_addr     (start_addr),
        .start_xfer     (start_xfer),
        .run            (run),
        .io_buffer_full (io_buffer_full_i),
        .ram_din        (ram_din_i),
        .ram_addr       (ram_addr_o),
        .ram_wr         (ram_wr_o),
        .ram_dout       (ram_dout_o),
        .last           (seq_last),
        .data_next      (data_next)
    );

    // Transaction FSM: launch, wait for the sequencer, pulse ready for one cycle, return to IDLE.
    // The ready pulse is registered, so a jump can only cancel it while still in IF_RD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            if_ready_o     <= Disable;
            if_inst_o      <= ZERO_WORD;
            is_if_output_o <= Disable;
            mem_ready_o    <= Disable;
            mem_rdata_o    <= ZERO_WORD;
        end else begin
            if_ready_o  <= Disable;
            mem_ready_o <= Disable;
            case (state)
                ST_IDLE: begin
                    if (mem_req_i) begin
                        state <= mem_we_i ? ST_MEM_WR : ST_MEM_RD;
                    end else if (if_req_i) begin
                        state          <= ST_IF_RD;
                        is_if_output_o <= Enable;
                    end
                end
                ST_IF_RD: begin
                    if (if_jump_i) begin
                        state          <= ST_IDLE;
                        is_if_output_o <= Disable;
                    end else if (seq_last) begin
                        state      <= ST_DONE;
                        if_ready_o <= Enable;
                        if_inst_o  <= data_next;
                    end
                end
                ST_MEM_RD: begin
                    if (seq_last) begin
                        state       <= ST_DONE;
                        mem_ready_o <= Enable;
                        mem_rdata_o <= data_next;
                    end
                end
                ST_MEM_WR: begin
                    if (seq_last) begin
                        state       <= ST_DONE;
                        mem_ready_o <= Enable;
                    end
                end
                ST_DONE: begin
                    state          <= ST_IDLE;
                    is_if_output_o <= Disable;
                end
                default: begin
                    state          <= ST_IDLE;
                    is_if_output_o <= Disable;
                end
            endcase
        end
    end

endmodule
